// File: rtl/reset_clock_pkg.sv
// Shared definitions for the reset/clock-enable sequencer: FSM encoding and
// the width helper for the divisor channel select.
package reset_clock_pkg;

  typedef enum logic [1:0] {
    ST_POWERUP = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } seq_state_t;

  // One code point beyond the last channel is always representable, so an
  // out-of-range select can reach the block and be rejected there.
  function automatic int sel_width(input int channels);
    return $clog2(channels + 1);
  endfunction

endpackage

// File: rtl/clock_enable_divider.sv
// One tick channel: emits a one-cycle tick every (div+1) cycles while released,
// and holds its own divisor register.
module clock_enable_divider #(
  parameter int DIV_WIDTH = 8,
  parameter int DIV_INIT  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 tick_q, tick_d;

  // A load is stored even while held, so a write alongside a sequence restart
  // is not lost; the count restarts from zero on either hold or load.
  always_comb begin
    div_d  = load ? div : div_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (hold || load) begin
      cnt_d = '0;
    end else if (cnt_q == div_q) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= DIV_WIDTH'(DIV_INIT);
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/reset_clock_sequencer.sv
// Power-up reset sequencer: holds all channels in reset, releases them in index
// order spaced by a fixed gap, then reports ready; drives one tick divider per channel.
module reset_clock_sequencer
  import reset_clock_pkg::*;
#(
  parameter int  CHANNELS       = 4,
  parameter int  CNT_WIDTH      = 24,
  parameter int  POWERUP_CYCLES = 6777216,
  parameter int  STAGE_GAP      = 16,
  parameter int  DIV_WIDTH      = 8,
  parameter int  DIV_INIT       = 0,
  localparam int SEL_W          = sel_width(CHANNELS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 soft_rst,
  input  logic                 div_we,
  input  logic [SEL_W-1:0]     div_sel,
  input  logic [DIV_WIDTH-1:0] div_value,
  output logic [CHANNELS-1:0]  ch_rst,
  output logic [CHANNELS-1:0]  ch_tick,
  output logic                 ready,
  output logic [1:0]           dbg_state
);

  // div_we is a single-cycle write strobe with no back-pressure: every cycle it
  // is high, div_value is taken for div_sel. ready is a status level, not a handshake.

  localparam logic [CNT_WIDTH-1:0] PU_END  = CNT_WIDTH'(POWERUP_CYCLES);
  localparam logic [CNT_WIDTH-1:0] GAP_END = CNT_WIDTH'(STAGE_GAP - 1);

  if (longint'(POWERUP_CYCLES) >= (longint'(1) << CNT_WIDTH) || POWERUP_CYCLES < 1) begin : g_bad_powerup
    $error("POWERUP_CYCLES does not fit in CNT_WIDTH");
  end
  if (STAGE_GAP < 1 || CHANNELS < 1 || CHANNELS > 16) begin : g_bad_shape
    $error("STAGE_GAP must be >= 1 and CHANNELS in 1..16");
  end

  seq_state_t            state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CHANNELS-1:0]   ch_rst_q, ch_rst_d, ch_rst_shift;
  logic                  ready_q, ready_d;
  logic                  stage_done;

  // Shifting a zero in from the bottom releases channels strictly in index order.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ch_rst_d     = ch_rst_q;
    ready_d      = ready_q;
    ch_rst_shift = ch_rst_q << 1;
    stage_done   = (state_q == ST_POWERUP) ? (cnt_q == PU_END) : (cnt_q == GAP_END);
    if (soft_rst) begin
      state_d  = ST_POWERUP;
      cnt_d    = '0;
      ch_rst_d = '1;
      ready_d  = 1'b0;
    end else begin
      case (state_q)
        ST_POWERUP, ST_RELEASE: begin
          if (stage_done) begin
            cnt_d    = '0;
            ch_rst_d = ch_rst_shift;
            if (ch_rst_shift == '0) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: ready_d = 1'b1;
        default: begin
          state_d  = ST_POWERUP;
          cnt_d    = '0;
          ch_rst_d = '1;
          ready_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_POWERUP;
      cnt_q    <= '0;
      ch_rst_q <= '1;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ch_rst_q <= ch_rst_d;
      ready_q  <= ready_d;
    end
  end

  // soft_rst joins the hold so ticks stop on the same edge the resets reassert.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    clock_enable_divider #(
      .DIV_WIDTH (DIV_WIDTH),
      .DIV_INIT  (DIV_INIT)
    ) u_div (
      .clk  (clk),
      .rst  (rst),
      .hold (ch_rst_q[k] | soft_rst),
      .load (div_we && (div_sel == SEL_W'(k))),
      .div  (div_value),
      .tick (ch_tick[k])
    );
  end

  assign ch_rst    = ch_rst_q;
  assign ready     = ready_q;
  assign dbg_state = state_q;

endmodule
